// File: rtl/axis_image_pkg.sv
// rtl/axis_image_pkg.sv - shared types and constants for the image pattern generator
package axis_image_pkg;

    typedef enum logic [1:0] {
        RAMP    = 2'd0,
        HGRAD   = 2'd1,
        CHECKER = 2'd2,
        COUNT   = 2'd3
    } pattern_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_e;

    // log2 of the checker tile edge (8x8 tiles)
    localparam int CHECKER_SHIFT = 3;

endpackage

// File: rtl/axis_image_xy_counter.sv
// rtl/axis_image_xy_counter.sv - raster x/y counters with load, advance and end-of-frame flags
module axis_image_xy_counter #(
    parameter int DIM_BITS = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                advance_i,
    input  logic [DIM_BITS-1:0] width_i,
    input  logic [DIM_BITS-1:0] height_i,
    output logic [DIM_BITS-1:0] x_next_o,
    output logic [DIM_BITS-1:0] y_next_o,
    output logic                eof_o,
    output logic                next_eof_o
);

    logic [DIM_BITS-1:0] x_q, y_q;
    logic [DIM_BITS-1:0] x_last_q, y_last_q;
    logic                eol;

    assign eol        = (x_q == x_last_q);
    assign eof_o      = eol && (y_q == y_last_q);
    assign x_next_o   = eol ? '0 : x_q + DIM_BITS'(1);
    assign y_next_o   = eol ? y_q + DIM_BITS'(1) : y_q;
    assign next_eof_o = (x_next_o == x_last_q) && (y_next_o == y_last_q);

    // Dimensions are stored as last-index so the flags are plain equality compares
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q      <= '0;
            y_q      <= '0;
            x_last_q <= '0;
            y_last_q <= '0;
        end else if (load_i) begin
            x_q      <= '0;
            y_q      <= '0;
            x_last_q <= width_i - DIM_BITS'(1);
            y_last_q <= height_i - DIM_BITS'(1);
        end else if (advance_i) begin
            x_q <= x_next_o;
            y_q <= y_next_o;
        end
    end

endmodule

// File: rtl/axis_image_pattern_gen.sv
// rtl/axis_image_pattern_gen.sv - AXI-Stream source emitting one procedural image frame per start
module axis_image_pattern_gen
    import axis_image_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIM_BITS  = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [DIM_BITS-1:0]  width_i,
    input  logic [DIM_BITS-1:0]  height_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] axis_s_data_o,
    output logic                 axis_s_valid_o,
    input  logic                 axis_s_ready_i,
    output logic                 axis_s_last_o
);

    gen_state_e          state_q, state_n;
    pattern_mode_e       mode_q;
    logic [DATA_BITS-1:0] count_q, count_next, pixel_next;
    logic [DIM_BITS-1:0] x_next, y_next;
    logic                eof, next_eof;
    logic                load, advance, hs, zero_dim;

    assign hs         = axis_s_valid_o & axis_s_ready_i;
    assign zero_dim   = (width_i == '0) || (height_i == '0);
    assign count_next = count_q + DATA_BITS'(1);

    axis_image_xy_counter #(
        .DIM_BITS(DIM_BITS)
    ) u_xy (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .advance_i  (advance),
        .width_i    (width_i),
        .height_i   (height_i),
        .x_next_o   (x_next),
        .y_next_o   (y_next),
        .eof_o      (eof),
        .next_eof_o (next_eof)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        load    = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_n = zero_dim ? DONE : RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    advance = 1'b1;
                    if (eof) state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pixel_next = '0;
        unique case (mode_q)
            RAMP:    pixel_next = DATA_BITS'(x_next) + DATA_BITS'(y_next);
            HGRAD:   pixel_next = DATA_BITS'(x_next);
            CHECKER: pixel_next = (x_next[CHECKER_SHIFT] ^ y_next[CHECKER_SHIFT]) ? '1 : '0;
            COUNT:   pixel_next = count_next;
            default: pixel_next = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q         <= RAMP;
            count_q        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            axis_s_valid_o <= 1'b0;
            axis_s_last_o  <= 1'b0;
            axis_s_data_o  <= '0;
        end else begin
            busy_o         <= (state_n == RUN);
            axis_s_valid_o <= (state_n == RUN);
            done_o         <= (state_n == DONE);
            if (load) begin
                // Pixel (0,0) with a zero index is 0 in every pattern
                mode_q        <= pattern_mode_e'(mode_i);
                count_q       <= '0;
                axis_s_data_o <= '0;
                axis_s_last_o <= (width_i == DIM_BITS'(1)) && (height_i == DIM_BITS'(1));
            end else if (advance) begin
                if (eof) begin
                    axis_s_data_o <= '0;
                    axis_s_last_o <= 1'b0;
                end else begin
                    count_q       <= count_next;
                    axis_s_data_o <= pixel_next;
                    axis_s_last_o <= next_eof;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_image_pattern_gen.sv
// tb/tb_axis_image_pattern_gen.sv - self-checking bench for axis_image_pattern_gen
module tb_axis_image_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [11:0] width, height;
    logic        busy, done, valid, ready, last;
    logic [7:0]  data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] cap [0:4095];

    typedef struct {
        int mode;
        int w;
        int h;
        bit rnd;
    } frame_t;

    typedef struct {
        int frame;
        int k;
        int exp;
    } vec_t;

    frame_t frames [8];
    vec_t   vecs   [16];

    always #5 clk = ~clk;

    axis_image_pattern_gen #(
        .DATA_BITS(8),
        .DIM_BITS (12)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .mode_i         (mode),
        .width_i        (width),
        .height_i       (height),
        .busy_o         (busy),
        .done_o         (done),
        .axis_s_data_o  (data),
        .axis_s_valid_o (valid),
        .axis_s_ready_i (ready),
        .axis_s_last_o  (last)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_pix(input int m, input int w, input int k);
        int x, y;
        x = k % w;
        y = k / w;
        case (m)
            0:       return (x + y) % 256;
            1:       return x % 256;
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 255 : 0;
            default: return k % 256;
        endcase
    endfunction

    // Stalled beats must hold data/last/valid until the handshake
    logic       pv = 1'b0, pr = 1'b0, prst = 1'b1, pl = 1'b0;
    logic [7:0] pd = 8'd0;
    always @(negedge clk) begin
        if (pv && !pr && !prst) begin
            chk("stall_valid", int'(valid), 1);
            chk("stall_data", int'(data), int'(pd));
            chk("stall_last", int'(last), int'(pl));
        end
        pv   <= valid;
        pr   <= ready;
        prst <= rst;
        pd   <= data;
        pl   <= last;
    end

    task automatic run_frame(input int m, input int w, input int h, input bit rnd, input int poke);
        int  total, beat, cyc;
        bit  poked;
        total = w * h;
        poked = 1'b0;
        @(posedge clk); #1;
        mode   = 2'(m);
        width  = 12'(w);
        height = 12'(h);
        start  = 1'b1;
        ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("first_valid", int'(valid), (total != 0) ? 1 : 0);
        beat = 0;
        cyc  = 0;
        while (beat < total && cyc < 5000) begin
            chk("busy_in_frame", int'(busy), 1);
            if (valid && ready) begin
                cap[beat] = data;
                chk($sformatf("data m%0d k%0d", m, beat), int'(data), model_pix(m, w, beat));
                chk($sformatf("last k%0d", beat), int'(last), (beat == total - 1) ? 1 : 0);
                beat++;
            end
            if (beat < total) begin
                @(posedge clk); #1;
                if (rnd) ready = 1'($urandom_range(0, 1));
                if (beat == poke && !poked) begin
                    start  = 1'b1;
                    mode   = 2'd3;
                    width  = 12'd7;
                    height = 12'd7;
                    poked  = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (beat < total) chk("frame_timeout_beats", beat, total);
        start = 1'b0;
        if (total != 0) @(negedge clk);
        chk("end_valid", int'(valid), 0);
        chk("end_last", int'(last), 0);
        chk("end_busy", int'(busy), 0);
        chk("end_done", int'(done), 1);
        @(negedge clk);
        chk("done_pulse_len", int'(done), 0);
        ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; width = 12'd0; height = 12'd0; ready = 1'b1;

        frames[0] = '{0, 4, 2, 1'b0};
        frames[1] = '{0, 4, 2, 1'b1};
        frames[2] = '{3, 300, 1, 1'b0};
        frames[3] = '{2, 16, 16, 1'b0};
        frames[4] = '{1, 20, 3, 1'b1};
        frames[5] = '{int'($urandom_range(0, 3)), int'($urandom_range(1, 40)), int'($urandom_range(1, 6)), 1'b1};
        frames[6] = '{0, 0, 5, 1'b0};
        frames[7] = '{2, 1, 1, 1'b1};

        vecs[0]  = '{0, 0, 0};   vecs[1]  = '{0, 1, 1};
        vecs[2]  = '{0, 3, 3};   vecs[3]  = '{0, 4, 1};
        vecs[4]  = '{0, 7, 4};   vecs[5]  = '{1, 5, 2};
        vecs[6]  = '{1, 7, 4};   vecs[7]  = '{2, 255, 255};
        vecs[8]  = '{2, 256, 0}; vecs[9]  = '{2, 299, 43};
        vecs[10] = '{3, 8, 255}; vecs[11] = '{3, 136, 0};
        vecs[12] = '{3, 128, 255}; vecs[13] = '{3, 119, 0};
        vecs[14] = '{4, 21, 1};  vecs[15] = '{4, 59, 19};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int f = 0; f < 8; f++) begin
            run_frame(frames[f].mode, frames[f].w, frames[f].h, frames[f].rnd, -1);
            for (int v = 0; v < 16; v++)
                if (vecs[v].frame == f)
                    chk($sformatf("vec f%0d k%0d", f, vecs[v].k), int'(cap[vecs[v].k]), vecs[v].exp);
        end

        // start pulsed mid-frame must not disturb the frame or queue another one
        run_frame(0, 4, 2, 1'b0, 3);
        repeat (3) begin
            @(negedge clk);
            chk("no_restart_valid", int'(valid), 0);
        end

        // reset while the third beat of a 4x4 frame is presented
        @(posedge clk); #1;
        mode = 2'd0; width = 12'd4; height = 12'd4; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_beat3_data", int'(data), 2);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", int'(valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_last", int'(last), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        run_frame(0, 4, 4, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_image_pattern_gen.md
# axis_image_pattern_gen

Synthesizable AXI-Stream image source that emits one raster-scan frame of procedurally generated pixels per start command, with `last` asserted on the final pixel of the frame. It is the transmitting end of the pixel stream the fixture consumes: it replaces file-driven stimulus with on-chip patterns for FPGA bring-up and for self-checking sims, using the same valid/ready/last stream semantics.

## Interface
- `DATA_BITS`, 8: pixel width; matches the fixture input width.
- `DIM_BITS`, 12: width of the frame-dimension and coordinate counters.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: start one frame; sampled only in IDLE.
- `mode_i` in 2: pattern select, latched at start: 0 RAMP, 1 HGRAD, 2 CHECKER, 3 COUNT.
- `width_i` in DIM_BITS: pixels per line, latched at start.
- `height_i` in DIM_BITS: lines per frame, latched at start.
- `busy_o` out 1: high from the accepted start until the final handshake.
- `done_o` out 1: one-cycle pulse after the frame completes.
- `axis_s_data_o` out DATA_BITS: pixel.
- `axis_s_valid_o` out 1: pixel valid.
- `axis_s_ready_i` in 1: downstream ready.
- `axis_s_last_o` out 1: final pixel of the frame.

## Operation
- FSM states:
  - IDLE: `start_i`=1 latches mode, width and height, clears x, y and the COUNT accumulator, then goes to RUN. If width==0 or height==0, goes to DONE instead and no beat is emitted.
  - RUN: presents pixel (x,y). On handshake (valid & ready): x++. When x==width-1, x←0 and y++. The handshake with x==width-1 and y==height-1 goes to DONE.
  - DONE: `done_o`=1 for one cycle, then IDLE.
- Pixel functions, truncated modulo 2^DATA_BITS:
  - RAMP = x+y.
  - HGRAD = x.
  - CHECKER = all-ones if (x[3]^y[3]), else 0 (8×8 tiles).
  - COUNT = linear pixel index, wrapping.
- `axis_s_last_o` = valid && x==width-1 && y==height-1. There is no per-line last.
- AXIS rules:
  - Once valid is high, data, last and valid stay stable until the handshake.
  - Valid never depends combinationally on ready.
- `start_i` in RUN or DONE is ignored. Config inputs are ignored outside the start cycle.
- Reset values: state IDLE; `axis_s_valid_o`=0, `axis_s_last_o`=0, `axis_s_data_o`=0, `busy_o`=0, `done_o`=0.
- Reset asserted mid-frame aborts the frame. No `last` and no `done` are produced.

## Timing
- Start sampled at edge N gives valid=1 with pixel (0,0) after edge N, i.e. in cycle N+1.
- All outputs are registered. The next pixel is computed combinationally from the next coordinates and registered on the handshake.
- Throughput is 1 pixel/cycle with ready held high. A W×H frame occupies W·H cycles of valid.
- Final handshake at edge M:
  - valid=0, last=0 and busy=0 after M.
  - done=1 during cycle M+1.
  - A new start is accepted at edge M+2 at the earliest.
- Zero-dimension start at edge N: done=1 in cycle N+1. Valid and busy stay 0.
- Ready low: valid holds and counters freeze. There is no bubble when ready returns.

## Structure
- Package `axis_image_pkg`:
  - `pattern_mode_e` enum (RAMP, HGRAD, CHECKER, COUNT).
  - `gen_state_e` enum (IDLE, RUN, DONE).
  - `CHECKER_SHIFT`=3.
- Sub-module `axis_image_xy_counter`:
  - Holds the x/y raster counters with load, advance and end-of-line / end-of-frame flags.
  - Reusable by a future stream sink or checker.
- Top level contains the FSM, pixel function mux and output registers.

## Test plan
- RAMP, W=4, H=2, ready=1:
  - Data 0,1,2,3,1,2,3,4.
  - last only on the 8th beat.
  - done 1 cycle after it; busy low from that same cycle.
- Same frame, ready toggling 1-0-0-1 pseudo-randomly:
  - Identical data sequence, no drops or duplicates.
  - Outputs stable while valid && !ready (assertion).
- COUNT, W=300, H=1, DATA_BITS=8:
  - Beat 255 has data 255, beat 256 has data 0.
  - last on beat 300.
- CHECKER, W=16, H=16: pixel (8,0)=0xFF, (8,8)=0x00, (0,8)=0xFF, (7,7)=0x00.
- W=0, H=5, start: valid never rises, done pulses in cycle N+1.
- Start pulsed during RUN has no effect.
- rst_i high during beat 3 of a 4×4 frame:
  - Next cycle valid=0 and busy=0, with no last and no done.
  - A following start produces a full 16-beat frame from (0,0).
